// File: rtl/uart_report_pkg.sv
// Shared types and constants for the UART report engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_report_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BANNER = 2'd1,
        ST_EVENT  = 2'd2,
        ST_ECHO   = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] CR         = 8'h0d;
    localparam logic [7:0] LF         = 8'h0a;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_report_engine_byte_fifo.sv
// Synchronous show-ahead byte FIFO with wrap-bit full/empty detection.
// Latency: a pushed byte is visible at the head on the cycle after the push.
// Backpressure: push ignored when full unless a pop frees the slot in the same cycle.
//
// Ports: sys_clk/sys_rst_n clock and async active-low reset; i_push/i_push_dat write
// side; i_pop read side; o_full/o_empty status; o_head_dat current head byte.
module byte_fifo
    import uart_report_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head_dat
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok   = i_pop && !o_empty;
    // When full, a simultaneous pop vacates the slot the write lands in.
    assign w_push_ok  = i_push && (!o_full || w_pop_ok);
    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/uart_report_engine.sv
// Merges periodic banner, debounced button-press events and RX echo onto one TX stream.
// Latency: pending source -> tx_data_valid on the next edge; >=1 idle cycle between messages.
// Backpressure: tx_data held while tx_data_ready low; RX never stalls, overflowing bytes are dropped.
//
// Ports: sys_clk/sys_rst_n; rx_data/rx_data_valid/rx_data_ready from uart_rx;
// btn_n raw active-low buttons; tx_data/tx_data_valid/tx_data_ready to uart_tx;
// btn_toggle per-button LED state; fifo_overflow sticky drop flag.
module uart_report_engine
    import uart_report_pkg::*;
#(
    parameter int                   CLK_FRE      = 27,
    parameter int                   PERIOD_CYC   = CLK_FRE * 1_000_000,
    parameter int                   DEBOUNCE_CYC = CLK_FRE * 10_000,
    parameter int                   FIFO_DEPTH   = 16,
    parameter int                   NUM_BTN      = 2,
    parameter int                   MSG_LEN      = 21,
    parameter logic [MSG_LEN*8-1:0] MSG          = {"Hello Tang Nano 20K", CR, LF}
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_data_valid,
    output logic               rx_data_ready,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic [7:0]         tx_data,
    output logic               tx_data_valid,
    input  logic               tx_data_ready,
    output logic [NUM_BTN-1:0] btn_toggle,
    output logic               fifo_overflow
);

    localparam int IDX_W = (MSG_LEN > 1) ? clog2(MSG_LEN) : 1;
    localparam int DB_W  = clog2(DEBOUNCE_CYC);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_tx_dat;
    logic [7:0]         w_tx_dat_nxt;
    logic               r_tx_vld;
    logic               w_tx_vld_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [2:0]         r_evt_idx;
    logic [2:0]         w_evt_idx_nxt;
    logic [2:0]         w_evt_sel;
    logic [NUM_BTN-1:0] r_evt_pending;
    logic [NUM_BTN-1:0] w_evt_clr;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] r_btn_toggle;
    logic               r_banner_pending;
    logic               w_banner_clr;
    logic [31:0]        r_period_cnt;
    logic               w_wrap;
    logic               r_overflow;
    logic               r_rx_rdy;
    logic               w_hs;
    logic               w_pop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [7:0]         w_fifo_head;

    assign tx_data       = r_tx_dat;
    assign tx_data_valid = r_tx_vld;
    assign btn_toggle    = r_btn_toggle;
    assign fifo_overflow = r_overflow;
    assign rx_data_ready = r_rx_rdy;
    assign w_hs          = r_tx_vld && tx_data_ready;
    assign w_wrap        = (r_period_cnt == 32'(PERIOD_CYC - 1));

    // First banner character sits in the MSBs.
    function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] idx);
        return MSG[(MSG_LEN - 1 - int'(idx)) * 8 +: 8];
    endfunction

    // Per-button synchroniser + debouncer. The counter runs only while the synchronised
    // level differs from the debounced one, so any bounce back restarts it.
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
        logic [1:0]      r_sync;
        logic [DB_W-1:0] r_cnt;
        logic            r_deb;

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_sync <= 2'b11;
                r_cnt  <= '0;
                r_deb  <= 1'b1;
            end else begin
                r_sync <= {r_sync[0], btn_n[gi]};
                if (r_sync[1] == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                    r_deb <= r_sync[1];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // Press = debounced level about to fall on this edge.
        assign w_press[gi] = r_deb && !r_sync[1] && (r_cnt == DB_W'(DEBOUNCE_CYC - 1));
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .i_push     (rx_data_valid),
        .i_push_dat (rx_data),
        .i_pop      (w_pop),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_head_dat (w_fifo_head)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_tx_dat_nxt  = r_tx_dat;
        w_tx_vld_nxt  = r_tx_vld;
        w_idx_nxt     = r_idx;
        w_evt_idx_nxt = r_evt_idx;
        w_evt_clr     = '0;
        w_banner_clr  = 1'b0;
        w_pop         = 1'b0;
        w_evt_sel     = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (r_evt_pending[i]) w_evt_sel = 3'(i);
        end

        case (r_state)
            ST_IDLE: begin
                if (!r_tx_vld) begin
                    if (|r_evt_pending) begin
                        w_evt_idx_nxt = w_evt_sel;
                        w_tx_dat_nxt  = ASCII_ZERO + {5'd0, w_evt_sel};
                        w_tx_vld_nxt  = 1'b1;
                        w_state_nxt   = ST_EVENT;
                    end else if (r_banner_pending) begin
                        w_banner_clr = 1'b1;
                        w_idx_nxt    = '0;
                        w_tx_dat_nxt = msg_byte('0);
                        w_tx_vld_nxt = 1'b1;
                        w_state_nxt  = ST_BANNER;
                    end else if (!w_fifo_empty) begin
                        w_tx_dat_nxt = w_fifo_head;
                        w_tx_vld_nxt = 1'b1;
                        w_state_nxt  = ST_ECHO;
                    end
                end
            end
            ST_BANNER: begin
                if (w_hs) begin
                    if (r_idx == IDX_W'(MSG_LEN - 1)) begin
                        w_tx_vld_nxt = 1'b0;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_idx_nxt    = r_idx + 1'b1;
                        w_tx_dat_nxt = msg_byte(r_idx + 1'b1);
                    end
                end
            end
            ST_EVENT: begin
                if (w_hs) begin
                    w_evt_clr    = NUM_BTN'(1) << r_evt_idx;
                    w_tx_vld_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_ECHO: begin
                if (w_hs) begin
                    w_pop        = 1'b1;
                    w_tx_vld_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_tx_vld_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tx_dat         <= '0;
            r_tx_vld         <= 1'b0;
            r_idx            <= '0;
            r_evt_idx        <= '0;
            r_evt_pending    <= '0;
            r_btn_toggle     <= '0;
            r_banner_pending <= 1'b1;
            r_period_cnt     <= '0;
            r_overflow       <= 1'b0;
            r_rx_rdy         <= 1'b0;
        end else begin
            r_tx_dat      <= w_tx_dat_nxt;
            r_tx_vld      <= w_tx_vld_nxt;
            r_idx         <= w_idx_nxt;
            r_evt_idx     <= w_evt_idx_nxt;
            r_rx_rdy      <= 1'b1;
            r_btn_toggle  <= r_btn_toggle ^ w_press;
            // A press landing in the handshake cycle keeps the flag set.
            r_evt_pending <= (r_evt_pending & ~w_evt_clr) | w_press;
            // A wrap on the entry cycle re-arms the request rather than being lost.
            r_banner_pending <= (r_banner_pending && !w_banner_clr) || w_wrap;
            r_period_cnt  <= w_wrap ? '0 : r_period_cnt + 1'b1;
            if (rx_data_valid && w_fifo_full && !w_pop) r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_report_engine.sv
// Directed self-checking bench for uart_report_engine.
// Latency: checks selection latency, banner continuity and period spacing.
// Backpressure: checks hold-under-stall and FIFO overflow drop behaviour.
module tb_uart_report_engine;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic [1:0] btn_n;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic [1:0] btn_toggle;
    logic       fifo_overflow;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned cyc = 0;
    logic [7:0]  log_q[$];
    int unsigned log_cyc[$];

    uart_report_engine #(
        .CLK_FRE      (27),
        .PERIOD_CYC   (200),
        .DEBOUNCE_CYC (8),
        .FIFO_DEPTH   (4),
        .NUM_BTN      (2),
        .MSG_LEN      (3),
        .MSG          ("Hi\n")
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .btn_n         (btn_n),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .btn_toggle    (btn_toggle),
        .fifo_overflow (fifo_overflow)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Record every transfer; inputs change just after posedge so negedge sees the
    // values the next posedge will act on.
    always @(negedge sys_clk) begin
        if (sys_rst_n && tx_data_valid && tx_data_ready) begin
            log_q.push_back(tx_data);
            log_cyc.push_back(cyc);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_reset();
        sys_rst_n     = 1'b0;
        rx_data_valid = 1'b0;
        rx_data       = 8'h00;
        btn_n         = 2'b11;
        wait_cycles(3);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst_n     = 1'b0;
        rx_data_valid = 1'b0;
        rx_data       = 8'h00;
        btn_n         = 2'b11;
        tx_data_ready = 1'b1;
        wait_cycles(2);
        n_checks++;
        if (tx_data_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", tx_data_valid); end
        n_checks++;
        if (tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_data got %h want 00", tx_data); end
        n_checks++;
        if (btn_toggle !== 2'b00) begin n_errors++; $display("FAIL reset_toggle got %b want 00", btn_toggle); end
        n_checks++;
        if (fifo_overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got %b want 0", fifo_overflow); end
        n_checks++;
        if (rx_data_ready !== 1'b0) begin n_errors++; $display("FAIL reset_rx_ready got %b want 0", rx_data_ready); end
        sys_rst_n = 1'b1;
        wait_cycles(1);
        n_checks++;
        if (rx_data_ready !== 1'b1) begin n_errors++; $display("FAIL rx_ready_after_reset got %b want 1", rx_data_ready); end
        n_checks++;
        if (tx_data_valid !== 1'b1 || tx_data !== 8'h48) begin
            n_errors++; $display("FAIL first_banner_latency got v=%b d=%h want v=1 d=48", tx_data_valid, tx_data);
        end
    endtask

    task automatic test_banner();
        int base;
        logic [7:0] exp[$];
        logic [7:0] got;
        tx_data_ready = 1'b1;
        apply_reset();
        base = log_q.size();
        wait_cycles(210);
        exp = '{8'h48, 8'h69, 8'h0a, 8'h48, 8'h69, 8'h0a};
        n_checks++;
        if (log_q.size() != base + exp.size()) begin
            n_errors++; $display("FAIL banner_count got %0d want %0d", log_q.size() - base, exp.size());
        end
        for (int k = 0; k < exp.size(); k++) begin
            got = (base + k < log_q.size()) ? log_q[base + k] : 8'hxx;
            n_checks++;
            if (got !== exp[k]) begin n_errors++; $display("FAIL banner_byte%0d got %h want %h", k, got, exp[k]); end
        end
        if (log_q.size() >= base + 4) begin
            n_checks++;
            if (log_cyc[base + 1] != log_cyc[base] + 1 || log_cyc[base + 2] != log_cyc[base] + 2) begin
                n_errors++; $display("FAIL banner_continuous got gaps %0d %0d want 1 2",
                    log_cyc[base + 1] - log_cyc[base], log_cyc[base + 2] - log_cyc[base]);
            end
            n_checks++;
            if (log_cyc[base + 3] != log_cyc[base] + 200) begin
                n_errors++; $display("FAIL banner_period got %0d want 200", log_cyc[base + 3] - log_cyc[base]);
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        logic [7:0] exp[$];
        logic [7:0] got;
        tx_data_ready = 1'b1;
        apply_reset();
        base = log_q.size();
        wait_cycles(2);
        tx_data_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            wait_cycles(1);
            n_checks++;
            if (tx_data !== 8'h69 || tx_data_valid !== 1'b1) begin
                n_errors++; $display("FAIL stall_hold%0d got v=%b d=%h want v=1 d=69", k, tx_data_valid, tx_data);
            end
        end
        tx_data_ready = 1'b1;
        wait_cycles(10);
        exp = '{8'h48, 8'h69, 8'h0a};
        n_checks++;
        if (log_q.size() != base + exp.size()) begin
            n_errors++; $display("FAIL stall_count got %0d want %0d", log_q.size() - base, exp.size());
        end
        for (int k = 0; k < exp.size(); k++) begin
            got = (base + k < log_q.size()) ? log_q[base + k] : 8'hxx;
            n_checks++;
            if (got !== exp[k]) begin n_errors++; $display("FAIL stall_byte%0d got %h want %h", k, got, exp[k]); end
        end
    endtask

    task automatic test_button();
        int base;
        logic [7:0] got;
        tx_data_ready = 1'b1;
        apply_reset();
        wait_cycles(10);
        base = log_q.size();
        for (int k = 0; k < 5; k++) begin
            btn_n[1] = k[0];
            wait_cycles(1);
        end
        btn_n[1] = 1'b0;
        wait_cycles(20);
        btn_n[1] = 1'b1;
        wait_cycles(20);
        n_checks++;
        if (btn_toggle !== 2'b10) begin n_errors++; $display("FAIL btn_toggle got %b want 10", btn_toggle); end
        // short glitch must be filtered
        btn_n[1] = 1'b0;
        wait_cycles(3);
        btn_n[1] = 1'b1;
        wait_cycles(20);
        n_checks++;
        if (log_q.size() != base + 1) begin
            n_errors++; $display("FAIL btn_event_count got %0d want 1", log_q.size() - base);
        end
        got = (base < log_q.size()) ? log_q[base] : 8'hxx;
        n_checks++;
        if (got !== 8'h31) begin n_errors++; $display("FAIL btn_event_byte got %h want 31", got); end
        n_checks++;
        if (btn_toggle !== 2'b10) begin n_errors++; $display("FAIL glitch_toggle got %b want 10", btn_toggle); end
    endtask

    task automatic test_priority();
        int base;
        int waited;
        logic [7:0] exp[$];
        logic [7:0] got;
        tx_data_ready = 1'b1;
        apply_reset();
        wait_cycles(10);
        base = log_q.size();
        tx_data_ready = 1'b0;
        // 0x40 occupies the engine so the rest can pile up behind it
        rx_data = 8'h40; rx_data_valid = 1'b1; wait_cycles(1); rx_data_valid = 1'b0;
        wait_cycles(3);
        rx_data = 8'h41; rx_data_valid = 1'b1; wait_cycles(1); rx_data_valid = 1'b0;
        btn_n[0] = 1'b0;
        wait_cycles(15);
        btn_n[0] = 1'b1;
        wait_cycles(200);
        tx_data_ready = 1'b1;
        wait_cycles(20);
        exp = '{8'h40, 8'h30, 8'h48, 8'h69, 8'h0a, 8'h41};
        n_checks++;
        if (log_q.size() != base + exp.size()) begin
            n_errors++; $display("FAIL prio_count got %0d want %0d", log_q.size() - base, exp.size());
        end
        for (int k = 0; k < exp.size(); k++) begin
            got = (base + k < log_q.size()) ? log_q[base + k] : 8'hxx;
            n_checks++;
            if (got !== exp[k]) begin n_errors++; $display("FAIL prio_byte%0d got %h want %h", k, got, exp[k]); end
        end
        // button pressed while a banner is stalled mid-flight
        tx_data_ready = 1'b0;
        base = log_q.size();
        waited = 0;
        while (tx_data_valid !== 1'b1 && waited < 300) begin
            wait_cycles(1);
            waited++;
        end
        n_checks++;
        if (tx_data_valid !== 1'b1 || tx_data !== 8'h48) begin
            n_errors++; $display("FAIL prio_banner_start got v=%b d=%h want v=1 d=48", tx_data_valid, tx_data);
        end
        btn_n[1] = 1'b0;
        wait_cycles(15);
        tx_data_ready = 1'b1;
        btn_n[1] = 1'b1;
        wait_cycles(20);
        exp = '{8'h48, 8'h69, 8'h0a, 8'h31};
        n_checks++;
        if (log_q.size() != base + exp.size()) begin
            n_errors++; $display("FAIL midbanner_count got %0d want %0d", log_q.size() - base, exp.size());
        end
        for (int k = 0; k < exp.size(); k++) begin
            got = (base + k < log_q.size()) ? log_q[base + k] : 8'hxx;
            n_checks++;
            if (got !== exp[k]) begin n_errors++; $display("FAIL midbanner_byte%0d got %h want %h", k, got, exp[k]); end
        end
        n_checks++;
        if (btn_toggle !== 2'b11) begin n_errors++; $display("FAIL prio_toggle got %b want 11", btn_toggle); end
    endtask

    task automatic test_overflow();
        int base;
        logic [7:0] got;
        tx_data_ready = 1'b1;
        apply_reset();
        wait_cycles(10);
        base = log_q.size();
        tx_data_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            rx_data       = 8'(k);
            rx_data_valid = 1'b1;
            wait_cycles(1);
        end
        rx_data_valid = 1'b0;
        wait_cycles(2);
        n_checks++;
        if (fifo_overflow !== 1'b1) begin n_errors++; $display("FAIL overflow_set got %b want 1", fifo_overflow); end
        tx_data_ready = 1'b1;
        wait_cycles(20);
        n_checks++;
        if (log_q.size() != base + 4) begin
            n_errors++; $display("FAIL overflow_count got %0d want 4", log_q.size() - base);
        end
        for (int k = 0; k < 4; k++) begin
            got = (base + k < log_q.size()) ? log_q[base + k] : 8'hxx;
            n_checks++;
            if (got !== 8'(k + 1)) begin n_errors++; $display("FAIL overflow_byte%0d got %h want %h", k, got, 8'(k + 1)); end
        end
        n_checks++;
        if (fifo_overflow !== 1'b1) begin n_errors++; $display("FAIL overflow_sticky got %b want 1", fifo_overflow); end
    endtask

    task automatic test_reset_mid_banner();
        int base;
        logic [7:0] exp[$];
        logic [7:0] got;
        tx_data_ready = 1'b0;
        apply_reset();
        base = log_q.size();
        wait_cycles(2);
        for (int k = 0; k < 6; k++) begin
            rx_data       = 8'h11 + 8'(k);
            rx_data_valid = 1'b1;
            wait_cycles(1);
        end
        rx_data_valid = 1'b0;
        n_checks++;
        if (fifo_overflow !== 1'b1) begin n_errors++; $display("FAIL rst_pre_overflow got %b want 1", fifo_overflow); end
        tx_data_ready = 1'b1;
        wait_cycles(2);
        n_checks++;
        if (log_q.size() != base + 2 || tx_data !== 8'h0a) begin
            n_errors++; $display("FAIL rst_pre_state got n=%0d d=%h want n=2 d=0a", log_q.size() - base, tx_data);
        end
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx_data_valid !== 1'b0 || tx_data !== 8'h00) begin
            n_errors++; $display("FAIL rst_async got v=%b d=%h want v=0 d=00", tx_data_valid, tx_data);
        end
        wait_cycles(2);
        base = log_q.size();
        sys_rst_n = 1'b1;
        wait_cycles(20);
        exp = '{8'h48, 8'h69, 8'h0a};
        n_checks++;
        if (log_q.size() != base + exp.size()) begin
            n_errors++; $display("FAIL rst_restart_count got %0d want %0d", log_q.size() - base, exp.size());
        end
        for (int k = 0; k < exp.size(); k++) begin
            got = (base + k < log_q.size()) ? log_q[base + k] : 8'hxx;
            n_checks++;
            if (got !== exp[k]) begin n_errors++; $display("FAIL rst_restart_byte%0d got %h want %h", k, got, exp[k]); end
        end
        n_checks++;
        if (fifo_overflow !== 1'b0) begin n_errors++; $display("FAIL rst_overflow_clear got %b want 0", fifo_overflow); end
    endtask

    initial begin
        test_reset();
        test_banner();
        test_backpressure();
        test_button();
        test_priority();
        test_overflow();
        test_reset_mid_banner();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
